// File: rtl/instr_ser_if.sv
// Command/byte-stream bundle for the instruction serializer.
// The master issues commands and sinks bytes; the serializer is the slave.
interface instr_ser_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [9:0] cmd_a;
    logic [9:0] cmd_b;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, out_ready,
        input  cmd_ready, out_byte, out_valid, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, out_ready,
        output cmd_ready, out_byte, out_valid, err
    );
endinterface

// File: rtl/instr_ser.sv
// Serializes do / don't / mul(a,b) commands into an ASCII byte stream,
// converting mul operands to decimal with a 10-cycle shift-add-3 pass.
module instr_ser (
    input  logic       clk,
    input  logic       rst,
    instr_ser_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONV, EMIT, ERR} state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DO   = 2'd1;
    localparam logic [1:0] OP_DONT = 2'd2;
    localparam logic [1:0] OP_RSV  = 2'd3;
    localparam logic [9:0] MAX_OPERAND = 10'd999;

    state_t      state, state_nx;
    logic        rdy_q;
    logic        ov_q, ov_nx;
    logic [7:0]  ob_q, ob_nx;
    logic        err_q, err_nx;
    logic [3:0]  byte_idx, idx_nx;
    logic [3:0]  bit_cnt;
    logic [1:0]  op_q;
    logic [9:0]  bin_a, bin_b;
    logic [11:0] bcd_a, bcd_b;
    logic        accept;
    logic        cmd_bad;

    // One double-dabble step: correct each digit >= 5, then shift in the next bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bin_bit);
        logic [11:0] adj;
        adj = bcd;
        for (int d = 0; d < 3; d++) begin
            if (adj[d*4 +: 4] >= 4'd5)
                adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        return {adj[10:0], bin_bit};
    endfunction

    function automatic int num_digits(input logic [11:0] bcd);
        if (bcd[11:8] != 4'd0) return 3;
        if (bcd[7:4] != 4'd0)  return 2;
        return 1;
    endfunction

    function automatic logic [7:0] digit_char(input logic [11:0] bcd, input int pos);
        logic [3:0] nib;
        case (pos)
            0:       nib = bcd[3:0];
            1:       nib = bcd[7:4];
            default: nib = bcd[11:8];
        endcase
        return 8'h30 + {4'h0, nib};
    endfunction

    function automatic logic [3:0] last_index(input logic [1:0] op,
                                              input logic [11:0] ba,
                                              input logic [11:0] bb);
        case (op)
            OP_DO:   return 4'd3;
            OP_DONT: return 4'd6;
            default: return 4'(5 + num_digits(ba) + num_digits(bb));
        endcase
    endfunction

    // mul layout: "mul(" A "," B ")" with A and B printed MSD-first, no leading zeros.
    function automatic logic [7:0] seq_byte(input logic [1:0] op,
                                            input logic [3:0] idx,
                                            input logic [11:0] ba,
                                            input logic [11:0] bb);
        int         i, na, nb;
        logic [7:0] ch;
        i  = int'(idx);
        na = num_digits(ba);
        nb = num_digits(bb);
        ch = 8'h00;
        case (op)
            OP_DO: begin
                case (idx)
                    4'd0:    ch = 8'h64;
                    4'd1:    ch = 8'h6F;
                    4'd2:    ch = 8'h28;
                    4'd3:    ch = 8'h29;
                    default: ch = 8'h00;
                endcase
            end
            OP_DONT: begin
                case (idx)
                    4'd0:    ch = 8'h64;
                    4'd1:    ch = 8'h6F;
                    4'd2:    ch = 8'h6E;
                    4'd3:    ch = 8'h27;
                    4'd4:    ch = 8'h74;
                    4'd5:    ch = 8'h28;
                    4'd6:    ch = 8'h29;
                    default: ch = 8'h00;
                endcase
            end
            default: begin
                if (i == 0)                 ch = 8'h6D;
                else if (i == 1)            ch = 8'h75;
                else if (i == 2)            ch = 8'h6C;
                else if (i == 3)            ch = 8'h28;
                else if (i < 4 + na)        ch = digit_char(ba, na - 1 - (i - 4));
                else if (i == 4 + na)       ch = 8'h2C;
                else if (i < 5 + na + nb)   ch = digit_char(bb, nb - 1 - (i - 5 - na));
                else                        ch = 8'h29;
            end
        endcase
        return ch;
    endfunction

    assign accept  = bus.cmd_valid && rdy_q && (state == IDLE);
    assign cmd_bad = (bus.cmd_op == OP_RSV) ||
                     ((bus.cmd_op == OP_MUL) &&
                      ((bus.cmd_a > MAX_OPERAND) || (bus.cmd_b > MAX_OPERAND)));

    // Reset masks the registered outputs in the same cycle so it wins over any handshake.
    assign bus.cmd_ready = rdy_q & ~rst;
    assign bus.out_valid = ov_q & ~rst;
    assign bus.out_byte  = rst ? 8'h00 : ob_q;
    assign bus.err       = err_q & ~rst;

    always_comb begin
        state_nx = state;
        idx_nx   = byte_idx;
        ov_nx    = ov_q;
        ob_nx    = ob_q;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                ov_nx = 1'b0;
                ob_nx = 8'h00;
                if (accept) begin
                    if (cmd_bad) begin
                        state_nx = ERR;
                        err_nx   = 1'b1;
                    end else if (bus.cmd_op == OP_MUL) begin
                        state_nx = CONV;
                    end else begin
                        state_nx = EMIT;
                        idx_nx   = 4'd0;
                        ov_nx    = 1'b1;
                        ob_nx    = seq_byte(bus.cmd_op, 4'd0, bcd_a, bcd_b);
                    end
                end
            end
            CONV: begin
                ov_nx = 1'b0;
                ob_nx = 8'h00;
                if (bit_cnt == 4'd9) begin
                    // First byte 'm' does not depend on the final BCD value.
                    state_nx = EMIT;
                    idx_nx   = 4'd0;
                    ov_nx    = 1'b1;
                    ob_nx    = 8'h6D;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (byte_idx == last_index(op_q, bcd_a, bcd_b)) begin
                        state_nx = IDLE;
                        idx_nx   = 4'd0;
                        ov_nx    = 1'b0;
                        ob_nx    = 8'h00;
                    end else begin
                        idx_nx = byte_idx + 4'd1;
                        ob_nx  = seq_byte(op_q, byte_idx + 4'd1, bcd_a, bcd_b);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                ov_nx    = 1'b0;
                ob_nx    = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rdy_q    <= 1'b1;
            ov_q     <= 1'b0;
            ob_q     <= 8'h00;
            err_q    <= 1'b0;
            byte_idx <= 4'd0;
        end else begin
            state    <= state_nx;
            rdy_q    <= (state_nx == IDLE);
            ov_q     <= ov_nx;
            ob_q     <= ob_nx;
            err_q    <= err_nx;
            byte_idx <= idx_nx;
        end
    end

    // Operand capture and the binary-to-BCD shift datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_a   <= 12'd0;
            bcd_b   <= 12'd0;
            bit_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= bus.cmd_op;
                        bin_a   <= bus.cmd_a;
                        bin_b   <= bus.cmd_b;
                        bcd_a   <= 12'd0;
                        bcd_b   <= 12'd0;
                        bit_cnt <= 4'd0;
                    end
                end
                CONV: begin
                    bcd_a   <= dabble_step(bcd_a, bin_a[9]);
                    bcd_b   <= dabble_step(bcd_b, bin_b[9]);
                    bin_a   <= {bin_a[8:0], 1'b0};
                    bin_b   <= {bin_b[8:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_ser.sv
// Directed plus randomized checks of instr_ser against a string-level model
// of the expected instruction text.
module tb_instr_ser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    instr_ser_if bus();

    instr_ser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string expected_text(input logic [1:0] op, input int a, input int b);
        case (op)
            2'd0:    return $sformatf("mul(%0d,%0d)", a, b);
            2'd1:    return "do()";
            2'd2:    return "don't()";
            default: return "";
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("wait_ready", bus.cmd_ready, 1);
    endtask

    // mode: 0 = out_ready held high, 1 = toggling, 2 = random; abort_at >= 0 pulses rst
    // once that many bytes have transferred.
    task automatic run_cmd(input logic [1:0] op, input int a, input int b,
                           input int mode, input int abort_at);
        string s;
        int    idx, cyc;
        bit    rdy, bad;
        bad = (op == 2'd3) || (op == 2'd0 && (a > 999 || b > 999));
        s   = expected_text(op, a, b);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = 10'(a);
        bus.cmd_b     = 10'(b);
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom);
        bus.cmd_a     = 10'($urandom);
        bus.cmd_b     = 10'($urandom);
        if (bad) begin
            chk("err_pulse", bus.err, 1);
            chk("err_no_valid", bus.out_valid, 0);
            chk("err_byte", bus.out_byte, 0);
            chk("err_busy", bus.cmd_ready, 0);
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            chk("err_clear", bus.err, 0);
            chk("err_ready", bus.cmd_ready, 1);
            chk("err_idle_valid", bus.out_valid, 0);
            return;
        end
        if (op == 2'd0) begin
            for (int k = 1; k <= 10; k++) begin
                chk("conv_valid", bus.out_valid, 0);
                chk("conv_byte", bus.out_byte, 0);
                chk("conv_busy", bus.cmd_ready, 0);
                bus.out_ready = 1'($urandom_range(0, 1));
                bus.cmd_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
            end
        end
        idx = 0;
        cyc = 0;
        while (idx < s.len() && cyc < 300) begin
            if (abort_at >= 0 && idx == abort_at) break;
            chk("emit_valid", bus.out_valid, 1);
            chk($sformatf("emit_byte[%0d]", idx), bus.out_byte, 32'(s[idx]));
            chk("emit_busy", bus.cmd_ready, 0);
            chk("emit_err", bus.err, 0);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            bus.cmd_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        if (abort_at >= 0) begin
            rst           = 1'b1;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'd1;
            bus.out_ready = 1'b1;
            for (int k = 0; k < 2; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk("rst_valid", bus.out_valid, 0);
                chk("rst_byte", bus.out_byte, 0);
                chk("rst_ready", bus.cmd_ready, 0);
                chk("rst_err", bus.err, 0);
            end
            bus.cmd_valid = 1'b0;
            rst = 1'b0;
            #1;
            chk("rst_release_ready", bus.cmd_ready, 1);
            @(posedge clk);
            @(negedge clk);
            chk("rst_after_ready", bus.cmd_ready, 1);
            chk("rst_after_valid", bus.out_valid, 0);
            return;
        end
        chk("emit_count", idx, s.len());
        chk("done_valid", bus.out_valid, 0);
        chk("done_byte", bus.out_byte, 0);
        chk("done_ready", bus.cmd_ready, 1);
        chk("done_err", bus.err, 0);
    endtask

    function automatic int pick_operand();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return 999;
        if (r == 2) return 1000 + $urandom_range(0, 23);
        return $urandom_range(0, 999);
    endfunction

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 10'd0;
        bus.cmd_b     = 10'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", bus.cmd_ready, 0);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_byte", bus.out_byte, 0);
        chk("reset_err", bus.err, 0);
        rst = 1'b0;
        #1;
        chk("release_ready", bus.cmd_ready, 1);

        run_cmd(2'd1, 0, 0, 0, -1);
        run_cmd(2'd2, 0, 0, 0, -1);
        run_cmd(2'd0, 123, 4, 0, -1);
        run_cmd(2'd0, 0, 999, 1, -1);
        run_cmd(2'd3, 5, 5, 0, -1);
        run_cmd(2'd0, 1000, 5, 0, -1);
        run_cmd(2'd0, 45, 67, 0, 3);
        run_cmd(2'd1, 0, 0, 0, -1);
        run_cmd(2'd0, 7, 1023, 2, -1);
        run_cmd(2'd0, 100, 10, 2, -1);

        for (int n = 0; n < 16; n++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            run_cmd(op, pick_operand(), pick_operand(), $urandom_range(0, 2), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/instr_ser.md
INSTR_SER -- requirements
Module: instr_ser

Interface
REQ-001 Parameters: none; operand range fixed at 0..999, three decimal digits max.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command; registered.
REQ-006 cmd_op  input  2  0=mul, 1=do, 2=don't, 3=reserved.
REQ-007 cmd_a  input  10  first mul operand, unsigned binary.
REQ-008 cmd_b  input  10  second mul operand, unsigned binary.
REQ-009 out_byte  output  8  ASCII byte of the serialized instruction.
REQ-010 out_valid  output  1  out_byte valid; registered.
REQ-011 out_ready  input  1  downstream accepts out_byte.
REQ-012 err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-013 Command transfer SHALL occur on a clk edge with cmd_valid=1 and cmd_ready=1; cmd_op, cmd_a and cmd_b SHALL be captured in that cycle (T).
REQ-014 cmd_ready SHALL be 1 only in IDLE, and SHALL be 0 from T+1 until the block returns to IDLE.
REQ-015 FSM states SHALL be IDLE, CONV, EMIT, ERR.
REQ-016 IDLE->EMIT on acceptance of do/don't; IDLE->CONV on acceptance of a valid mul; IDLE->ERR on op=3 or on a mul with cmd_a>999 or cmd_b>999.
REQ-017 ERR SHALL last exactly one cycle (T+1), with err=1 and out_valid=0, then return to IDLE; cmd_ready SHALL be 1 at T+2.
REQ-018 CONV SHALL convert both operands to BCD in parallel, one bit per cycle (shift-add-3), occupying exactly cycles T+1..T+10; out_valid SHALL be 0 throughout.
REQ-019 First out_valid=1 SHALL occur at T+1 for do/don't and at T+11 for mul.
REQ-020 Byte sequences SHALL be: do "do()" (64 6F 28 29); don't "don't()" (64 6F 6E 27 74 28 29); mul "mul(" A "," B ")".
REQ-021 Operand digits SHALL be most-significant first, with leading zeros suppressed; a value of 0 SHALL emit the single digit "0" (0x30); mul length is 8..12 bytes.
REQ-022 A byte transfers on a clk edge with out_valid=1 and out_ready=1; the next byte SHALL be presented the following cycle, giving 1 byte/cycle when out_ready is held 1.
REQ-023 While out_valid=1 and out_ready=0, out_byte SHALL hold stable, and out_valid SHALL NOT deassert.
REQ-024 After the final byte ')' transfers, out_valid SHALL be 0 and cmd_ready SHALL be 1 in the next cycle; there are no back-to-back commands without this one IDLE cycle.
REQ-025 out_byte SHALL be 0x00 whenever out_valid=0.
REQ-026 cmd_valid SHALL be ignored while cmd_ready=0; inputs SHALL NOT be re-sampled mid-command.
REQ-027 out_ready SHALL have no effect outside EMIT.

Reset
REQ-028 While rst=1: cmd_ready=0, out_valid=0, out_byte=0x00, err=0, FSM=IDLE, BCD and byte-index registers cleared.
REQ-029 The first cycle after rst deasserts SHALL have cmd_ready=1.
REQ-030 rst asserted during CONV/EMIT/ERR SHALL abandon the command; no further bytes of it SHALL be emitted after reset.
REQ-031 rst SHALL take priority over cmd_valid and out_ready in the same cycle.

Verification
REQ-032 op=1, out_ready=1 -> 64 6F 28 29 on T+1..T+4; cmd_ready=1 at T+5.
REQ-033 op=2, out_ready=1 -> 64 6F 6E 27 74 28 29 on T+1..T+7; err stays 0.
REQ-034 op=0, a=123, b=4, out_ready=1 -> out_valid=0 on T+1..T+10; "mul(123,4)" (6D 75 6C 28 31 32 33 2C 34 29) on T+11..T+20.
REQ-035 op=0, a=0, b=999, out_ready toggling 1/0 -> "mul(0,999)" exactly once; out_byte stable through each stall.
REQ-036 op=3, then op=0 with a=1000 -> err=1 at T+1 for each; no out_valid; cmd_ready=1 at T+2.
REQ-037 rst pulsed after the 3rd byte of "mul(45,67)" -> out_valid=0 during reset, cmd_ready=1 the cycle after, and the next command "do()" is emitted intact.
